// File: rtl/sca_pkg.sv
// Shared types and defaults for the SCA pulse qualifier: FSM states, event classes
// and the over > short > good classification rule used when a pulse ends.
package sca_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    STUCK,
    DEAD
  } state_e;

  typedef enum logic [1:0] {
    GOOD,
    OVER,
    SHORT,
    LONG
  } evt_class_e;

  localparam int DEF_WIDTH_BITS  = 16;
  localparam int DEF_MIN_WIDTH   = 4;
  localparam int DEF_MAX_WIDTH   = 1024;
  localparam int DEF_DEAD_CYCLES = 64;
  localparam int DEF_CNT_WIDTH   = 32;

  function automatic evt_class_e classify(input logic over, input logic short_pulse);
    if (over) begin
      return OVER;
    end else if (short_pulse) begin
      return SHORT;
    end else begin
      return GOOD;
    end
  endfunction

endpackage

// File: rtl/sca_event_counter.sv
// Saturating event counter with synchronous clear; clear wins over a coincident increment.
module sca_event_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sca_pulse_qualifier.sv
// Single-channel-analyser pulse qualifier: measures vll pulses, classifies them and
// applies a dead time. Define SCA_COUNTERS_EN to add the good/rejected event counters.
module sca_pulse_qualifier
  import sca_pkg::*;
#(
  parameter int WIDTH_BITS  = DEF_WIDTH_BITS,
  parameter int MIN_WIDTH   = DEF_MIN_WIDTH,
  parameter int MAX_WIDTH   = DEF_MAX_WIDTH,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                  adc_clk,
  input  logic                  rst,
  input  logic                  vll,
  input  logic                  vlh,
  output logic                  evt_good,
  output logic                  evt_over,
  output logic                  evt_short,
  output logic                  evt_long,
  output logic [WIDTH_BITS-1:0] pulse_width,
  output logic                  busy
`ifdef SCA_COUNTERS_EN
  ,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  good_cnt,
  output logic [CNT_WIDTH-1:0]  rej_cnt
`endif
);

  localparam int DEAD_BITS = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DEAD_BITS-1:0] DEAD_LOAD =
    DEAD_BITS'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [WIDTH_BITS-1:0] MAX_W = WIDTH_BITS'(MAX_WIDTH);
  localparam logic [WIDTH_BITS-1:0] MIN_W = WIDTH_BITS'(MIN_WIDTH);
  localparam state_e END_STATE = (DEAD_CYCLES > 0) ? DEAD : IDLE;

  // Empty marker blocks make an illegal configuration visible in the elaborated hierarchy.
  if (MAX_WIDTH >= (64'd1 << WIDTH_BITS)) begin : g_max_width_too_large
  end
  if (CNT_WIDTH < 1) begin : g_cnt_width_invalid
  end

  state_e                state, state_nxt;
  logic [WIDTH_BITS-1:0] width_cnt, width_nxt, width_inc;
  logic                  over_flag, over_nxt;
  logic [DEAD_BITS-1:0]  dead_cnt, dead_nxt;
  logic [WIDTH_BITS-1:0] pw_nxt;
  logic                  fire;
  evt_class_e            fire_class;

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state       <= IDLE;
      width_cnt   <= '0;
      over_flag   <= 1'b0;
      dead_cnt    <= '0;
      evt_good    <= 1'b0;
      evt_over    <= 1'b0;
      evt_short   <= 1'b0;
      evt_long    <= 1'b0;
      pulse_width <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      width_cnt   <= width_nxt;
      over_flag   <= over_nxt;
      dead_cnt    <= dead_nxt;
      evt_good    <= fire && (fire_class == GOOD);
      evt_over    <= fire && (fire_class == OVER);
      evt_short   <= fire && (fire_class == SHORT);
      evt_long    <= fire && (fire_class == LONG);
      pulse_width <= pw_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

  // The end sample's vlh is not folded into the over flag: only vll=1 samples count.
  always_comb begin
    state_nxt  = state;
    width_nxt  = width_cnt;
    over_nxt   = over_flag;
    dead_nxt   = dead_cnt;
    pw_nxt     = pulse_width;
    fire       = 1'b0;
    fire_class = GOOD;
    width_inc  = width_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (vll) begin
          width_nxt = WIDTH_BITS'(1);
          over_nxt  = ~vlh;
          state_nxt = PULSE;
          if (MAX_W == WIDTH_BITS'(1)) begin
            fire       = 1'b1;
            fire_class = LONG;
            pw_nxt     = MAX_W;
            state_nxt  = STUCK;
          end
        end
      end

      PULSE: begin
        if (vll) begin
          width_nxt = width_inc;
          over_nxt  = over_flag | ~vlh;
          if (width_inc == MAX_W) begin
            fire       = 1'b1;
            fire_class = LONG;
            pw_nxt     = MAX_W;
            state_nxt  = STUCK;
          end
        end else begin
          fire       = 1'b1;
          fire_class = classify(over_flag, width_cnt < MIN_W);
          pw_nxt     = width_cnt;
          state_nxt  = END_STATE;
          dead_nxt   = DEAD_LOAD;
        end
      end

      STUCK: begin
        if (!vll) begin
          state_nxt = END_STATE;
          dead_nxt  = DEAD_LOAD;
        end
      end

      DEAD: begin
        if (dead_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          dead_nxt = dead_cnt - 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef SCA_COUNTERS_EN
  sca_event_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_good_counter (
    .clk   (adc_clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (fire && (fire_class == GOOD)),
    .count (good_cnt)
  );

  sca_event_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_rej_counter (
    .clk   (adc_clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (fire && (fire_class != GOOD)),
    .count (rej_cnt)
  );
`endif

endmodule

// File: tb/tb_sca_pulse_qualifier.sv
// Self-checking bench for sca_pulse_qualifier: time-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations. Honours SCA_COUNTERS_EN.
module tb_sca_pulse_qualifier;

  localparam int WB    = 16;
  localparam int MINW  = 4;
  localparam int MAXW  = 1024;
  localparam int DEADC = 64;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          vll;
  logic          vlh;
  logic          cnt_clr;
  logic          evt_good, evt_over, evt_short, evt_long, busy;
  logic [WB-1:0] pulse_width;
`ifdef SCA_COUNTERS_EN
  logic [CW-1:0] good_cnt, rej_cnt;
`endif

  always #5 clk = ~clk;

  sca_pulse_qualifier #(
    .WIDTH_BITS  (WB),
    .MIN_WIDTH   (MINW),
    .MAX_WIDTH   (MAXW),
    .DEAD_CYCLES (DEADC),
    .CNT_WIDTH   (CW)
  ) dut (
    .adc_clk     (clk),
    .rst         (rst),
    .vll         (vll),
    .vlh         (vlh),
    .evt_good    (evt_good),
    .evt_over    (evt_over),
    .evt_short   (evt_short),
    .evt_long    (evt_long),
    .pulse_width (pulse_width),
    .busy        (busy)
`ifdef SCA_COUNTERS_EN
    ,
    .cnt_clr     (cnt_clr),
    .good_cnt    (good_cnt),
    .rej_cnt     (rej_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Reference model: a pulse is a run of vll=1 samples; the input is re-armed once the
  // cycle number passes the recorded end time plus the dead time.
  bit     m_in, m_stuck, m_ovr;
  int     m_len;
  int     m_armed_at = 0;
  bit     e_good, e_over, e_short, e_long, e_busy;
  int     e_pw;
  longint e_good_cnt, e_rej_cnt;

  always @(posedge clk) begin
    cyc++;
    e_good  = 1'b0;
    e_over  = 1'b0;
    e_short = 1'b0;
    e_long  = 1'b0;
    if (rst) begin
      m_in       = 1'b0;
      m_stuck    = 1'b0;
      m_armed_at = cyc;
      e_pw       = 0;
      e_busy     = 1'b0;
      e_good_cnt = 0;
      e_rej_cnt  = 0;
    end else begin
      if (m_in) begin
        if (vll) begin
          m_len++;
          m_ovr = m_ovr | !vlh;
          if (m_len == MAXW) begin
            e_long  = 1'b1;
            e_pw    = MAXW;
            m_in    = 1'b0;
            m_stuck = 1'b1;
          end
        end else begin
          m_in = 1'b0;
          e_pw = m_len;
          if (m_ovr) e_over = 1'b1;
          else if (m_len < MINW) e_short = 1'b1;
          else e_good = 1'b1;
          m_armed_at = cyc + DEADC;
        end
      end else if (m_stuck) begin
        if (!vll) begin
          m_stuck    = 1'b0;
          m_armed_at = cyc + DEADC;
        end
      end else if (vll && cyc > m_armed_at) begin
        m_in  = 1'b1;
        m_len = 1;
        m_ovr = !vlh;
      end
      e_busy = m_in || m_stuck || (cyc < m_armed_at);
      if (cnt_clr) begin
        e_good_cnt = 0;
        e_rej_cnt  = 0;
      end else if (e_good) begin
        if (e_good_cnt < 64'hFFFF_FFFF) e_good_cnt++;
      end else if (e_over || e_short || e_long) begin
        if (e_rej_cnt < 64'hFFFF_FFFF) e_rej_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      checkOutput("evt_good", evt_good, e_good);
      checkOutput("evt_over", evt_over, e_over);
      checkOutput("evt_short", evt_short, e_short);
      checkOutput("evt_long", evt_long, e_long);
      checkOutput("pulse_width", pulse_width, e_pw);
      checkOutput("busy", busy, e_busy);
`ifdef SCA_COUNTERS_EN
      checkOutput("good_cnt", good_cnt, e_good_cnt);
      checkOutput("rej_cnt", rej_cnt, e_rej_cnt);
`endif
    end
  end

  // Running totals of observed DUT activity: good, over, short, long, busy cycles.
  int tot[5];
  int base[5];

  always @(negedge clk) begin
    if (cyc > 0) begin
      tot[0] += int'(evt_good);
      tot[1] += int'(evt_over);
      tot[2] += int'(evt_short);
      tot[3] += int'(evt_long);
      tot[4] += int'(busy);
    end
  end

  task automatic snapshot();
    for (int i = 0; i < 5; i++) base[i] = tot[i];
  endtask

  task automatic checkScenario(input string name, input int g, input int o, input int s,
                               input int l, input int pw, input int busy_cycles);
    checkOutput({name, "_good"}, tot[0] - base[0], g);
    checkOutput({name, "_over"}, tot[1] - base[1], o);
    checkOutput({name, "_short"}, tot[2] - base[2], s);
    checkOutput({name, "_long"}, tot[3] - base[3], l);
    checkOutput({name, "_pw"}, pulse_width, pw);
    checkOutput({name, "_model_pw"}, e_pw, pw);
    if (busy_cycles >= 0) checkOutput({name, "_busy_cycles"}, tot[4] - base[4], busy_cycles);
  endtask

  // Drives len samples of vll=1 (vlh=0 on sample low_at), then vll=0; the next
  // pulse's first sample lands gap cycles after the end sample.
  task automatic applyStimulus(input int len, input int low_at, input int gap,
                               input bit clr_at_end);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      vll = 1'b1;
      vlh = (i == low_at) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    vll     = 1'b0;
    vlh     = 1'b1;
    cnt_clr = clr_at_end;
    @(negedge clk);
    cnt_clr = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog at cycle %0d: simulation did not complete", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    vll     = 1'b0;
    vlh     = 1'b1;
    cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_pw", pulse_width, 0);
    checkOutput("reset_strobes", {evt_good, evt_over, evt_short, evt_long}, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] good pulse of 10");
    snapshot();
    applyStimulus(10, -1, 80, 1'b0);
    checkScenario("good10", 1, 0, 0, 0, 10, 74);

    $display("[TB] over-range pulse of 10");
    snapshot();
    applyStimulus(10, 4, 80, 1'b0);
    checkScenario("over10", 0, 1, 0, 0, 10, 74);

    $display("[TB] short pulse then pulse inside dead time");
    snapshot();
    applyStimulus(3, -1, 20, 1'b0);
    applyStimulus(10, -1, 80, 1'b0);
    checkScenario("short_dead", 0, 0, 1, 0, 3, 67);

    $display("[TB] short pulse then pulse at first re-armed cycle");
    snapshot();
    applyStimulus(3, -1, 65, 1'b0);
    applyStimulus(10, -1, 80, 1'b0);
    checkScenario("short_rearm", 1, 0, 1, 0, 10, -1);

    $display("[TB] pulse still high at re-arm");
    snapshot();
    applyStimulus(3, -1, 64, 1'b0);
    applyStimulus(10, -1, 80, 1'b0);
    checkScenario("straddle", 1, 0, 1, 0, 9, -1);

    $display("[TB] boundary widths and priority");
    snapshot();
    applyStimulus(4, -1, 80, 1'b0);
    checkScenario("min_width", 1, 0, 0, 0, 4, 68);
    snapshot();
    applyStimulus(6, 0, 80, 1'b0);
    checkScenario("over_entry", 0, 1, 0, 0, 6, 70);
    snapshot();
    applyStimulus(2, 1, 80, 1'b0);
    checkScenario("over_short", 0, 1, 0, 0, 2, 66);

    $display("[TB] long pulse of 2000");
    snapshot();
    applyStimulus(2000, -1, 80, 1'b0);
    checkScenario("long", 0, 0, 0, 1, MAXW, 2064);

    $display("[TB] reset mid-pulse");
    snapshot();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vll = 1'b1;
      vlh = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vll = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    repeat (80) @(negedge clk);
    checkScenario("midrst", 0, 0, 0, 0, 0, 5);
    snapshot();
    applyStimulus(10, -1, 80, 1'b0);
    checkScenario("after_rst", 1, 0, 0, 0, 10, 74);

`ifdef SCA_COUNTERS_EN
    $display("[TB] event counters");
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(8, -1, 70, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(2, -1, 70, 1'b0);
    checkOutput("cnt_good5", good_cnt, 5);
    checkOutput("cnt_rej3", rej_cnt, 3);
    applyStimulus(8, -1, 70, 1'b0);
    checkOutput("cnt_good6", good_cnt, 6);
    applyStimulus(8, -1, 70, 1'b1);
    checkOutput("cnt_clr_good", good_cnt, 0);
    checkOutput("cnt_clr_rej", rej_cnt, 0);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
